// File: rtl/axis_hdr_pkg.sv
// Shared state encoding and keep-mask helpers for the header-extract stream stage.
package axis_hdr_pkg;

  localparam int KEEP_MAX = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HDR   = 2'd1,
    BODY  = 2'd2,
    FLUSH = 2'd3
  } state_t;

  function automatic int popcount_keep(input logic [KEEP_MAX-1:0] keep);
    int n;
    n = 0;
    for (int i = 0; i < KEEP_MAX; i++) n += int'(keep[i]);
    return n;
  endfunction

  // n ones in the low bits
  function automatic logic [KEEP_MAX-1:0] keep_right(input int n);
    logic [KEEP_MAX-1:0] m;
    m = '0;
    for (int i = 0; i < KEEP_MAX; i++) if (i < n) m[i] = 1'b1;
    return m;
  endfunction

  // n ones ending at bit w-1
  function automatic logic [KEEP_MAX-1:0] keep_left(input int n, input int w);
    logic [KEEP_MAX-1:0] m;
    m = '0;
    for (int i = 0; i < KEEP_MAX; i++) if (i < w && i >= w - n) m[i] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/axis_realign_merge.sv
// Appends an input beat behind R left-aligned residual bytes; splits the overflow into a new residual.
module axis_realign_merge #(
  parameter int DATA_WD = 32,
  parameter int CNT_WD  = 3
) (
  input  logic [DATA_WD-1:0] res_data,
  input  logic [CNT_WD-1:0]  res_cnt,
  input  logic [DATA_WD-1:0] beat_data,
  input  logic [CNT_WD-1:0]  beat_cnt,
  output logic [DATA_WD-1:0] merged_data,
  output logic [CNT_WD:0]    merged_cnt,
  output logic [DATA_WD-1:0] next_res_data,
  output logic [CNT_WD-1:0]  next_res_cnt
);
  localparam int NB = DATA_WD / 8;

  int r;
  int total;

  // residual unused bytes are zero, so OR-ing in the shifted beat is safe
  always_comb begin
    r             = int'(res_cnt);
    total         = r + int'(beat_cnt);
    merged_data   = res_data | (beat_data >> (8 * r));
    merged_cnt    = (CNT_WD + 1)'(total);
    next_res_data = (r == 0) ? '0 : (beat_data << (8 * (NB - r)));
    next_res_cnt  = (total > NB) ? CNT_WD'(total - NB) : '0;
  end

endmodule

// File: rtl/axi_stream_extract_header.sv
// Splits the leading hdr_len bytes of each AXI-Stream packet onto a header port and
// re-packs the remaining payload so it starts at the MSB byte of its first beat.
module axi_stream_extract_header
  import axis_hdr_pkg::*;
#(
  parameter int DATA_WD      = 32,
  parameter int DATA_BYTE_WD = DATA_WD / 8,
  parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    valid_len,
  input  logic [BYTE_CNT_WD:0]    hdr_len,
  output logic                    ready_len,
  input  logic                    valid_in,
  input  logic [DATA_WD-1:0]      data_in,
  input  logic [DATA_BYTE_WD-1:0] keep_in,
  input  logic                    last_in,
  output logic                    ready_in,
  output logic                    valid_hdr,
  output logic [DATA_WD-1:0]      header_out,
  output logic [DATA_BYTE_WD-1:0] keep_hdr,
  input  logic                    ready_hdr,
  output logic                    valid_out,
  output logic [DATA_WD-1:0]      data_out,
  output logic [DATA_BYTE_WD-1:0] keep_out,
  output logic                    last_out,
  input  logic                    ready_out,
  output logic                    err_short
);
  localparam int CNT_WD = BYTE_CNT_WD + 1;

  state_t                  state, state_nx;
  logic [CNT_WD-1:0]       len, res_cnt, next_res_cnt;
  logic [DATA_WD-1:0]      res_data, beat_data, merged_data, next_res_data, hdr_data_nx;
  logic [CNT_WD:0]         merged_cnt;
  logic [DATA_BYTE_WD-1:0] hdr_keep_nx, out_keep_nx;
  int                      beat_cnt, len_i, len_sat, merged_i, hdr_n, out_n;
  logic                    hdr_free, out_free, accept, short_hdr;

  // bytes outside keep_in are forced to zero so they never leak into outputs
  always_comb begin
    for (int b = 0; b < DATA_BYTE_WD; b++)
      beat_data[8*b +: 8] = keep_in[b] ? data_in[8*b +: 8] : 8'h00;
  end

  assign beat_cnt  = popcount_keep(KEEP_MAX'(keep_in));
  assign len_i     = int'(len);
  assign merged_i  = int'(merged_cnt);
  assign len_sat   = (hdr_len == '0 || int'(hdr_len) > DATA_BYTE_WD) ? DATA_BYTE_WD : int'(hdr_len);
  assign short_hdr = beat_cnt < len_i;
  assign hdr_free  = !valid_hdr || ready_hdr;
  assign out_free  = !valid_out || ready_out;
  assign accept    = valid_in && ready_in;

  axis_realign_merge #(
    .DATA_WD (DATA_WD),
    .CNT_WD  (CNT_WD)
  ) u_merge (
    .res_data      (res_data),
    .res_cnt       (res_cnt),
    .beat_data     (beat_data),
    .beat_cnt      (CNT_WD'(beat_cnt)),
    .merged_data   (merged_data),
    .merged_cnt    (merged_cnt),
    .next_res_data (next_res_data),
    .next_res_cnt  (next_res_cnt)
  );

  always_comb begin
    hdr_n       = short_hdr ? beat_cnt : len_i;
    hdr_data_nx = beat_data >> (8 * (DATA_BYTE_WD - hdr_n));
    hdr_keep_nx = DATA_BYTE_WD'(keep_right(hdr_n));
    case (state)
      HDR:     out_n = beat_cnt - len_i;
      FLUSH:   out_n = int'(res_cnt);
      default: out_n = (merged_i > DATA_BYTE_WD) ? DATA_BYTE_WD : merged_i;
    endcase
    out_keep_nx = DATA_BYTE_WD'(keep_left(out_n, DATA_BYTE_WD));
  end

  always_comb begin
    state_nx = state;
    ready_in = 1'b0;
    case (state)
      IDLE:  if (valid_len && ready_len) state_nx = HDR;
      HDR: begin
        ready_in = hdr_free && out_free;
        if (valid_in && ready_in) state_nx = (short_hdr || last_in) ? IDLE : BODY;
      end
      BODY: begin
        ready_in = out_free;
        if (valid_in && ready_in && last_in)
          state_nx = (merged_i > DATA_BYTE_WD) ? FLUSH : IDLE;
      end
      FLUSH: if (out_free) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      ready_len  <= 1'b0;
      len        <= '0;
      res_cnt    <= '0;
      res_data   <= '0;
      valid_hdr  <= 1'b0;
      header_out <= '0;
      keep_hdr   <= '0;
      valid_out  <= 1'b0;
      data_out   <= '0;
      keep_out   <= '0;
      last_out   <= 1'b0;
      err_short  <= 1'b0;
    end else begin
      state     <= state_nx;
      ready_len <= (state_nx == IDLE);
      err_short <= 1'b0;
      if (ready_hdr) valid_hdr <= 1'b0;
      if (ready_out) valid_out <= 1'b0;
      if (state == IDLE && valid_len && ready_len) len <= CNT_WD'(len_sat);
      case (state)
        HDR: if (accept) begin
          valid_hdr  <= 1'b1;
          header_out <= hdr_data_nx;
          keep_hdr   <= hdr_keep_nx;
          err_short  <= short_hdr;
          res_data   <= beat_data << (8 * len_i);
          res_cnt    <= (short_hdr || last_in) ? '0 : CNT_WD'(beat_cnt - len_i);
          // single-beat packet: leftover bytes go straight out as the final beat
          if (!short_hdr && last_in && beat_cnt > len_i) begin
            valid_out <= 1'b1;
            data_out  <= beat_data << (8 * len_i);
            keep_out  <= out_keep_nx;
            last_out  <= 1'b1;
          end
        end
        BODY: if (accept) begin
          valid_out <= 1'b1;
          data_out  <= merged_data;
          keep_out  <= out_keep_nx;
          last_out  <= last_in && (merged_i <= DATA_BYTE_WD);
          res_data  <= next_res_data;
          res_cnt   <= next_res_cnt;
        end
        FLUSH: if (out_free) begin
          valid_out <= 1'b1;
          data_out  <= res_data;
          keep_out  <= out_keep_nx;
          last_out  <= 1'b1;
          res_cnt   <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_stream_extract_header.sv
// Scoreboard bench for axi_stream_extract_header with a byte-stream reference model.
module tb_axi_stream_extract_header;
  localparam int NB = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid_len = 1'b0;
  logic [2:0]  hdr_len = '0;
  logic        ready_len;
  logic        valid_in = 1'b0;
  logic [31:0] data_in = '0;
  logic [3:0]  keep_in = '0;
  logic        last_in = 1'b0;
  logic        ready_in;
  logic        valid_hdr;
  logic [31:0] header_out;
  logic [3:0]  keep_hdr;
  logic        ready_hdr = 1'b1;
  logic        valid_out;
  logic [31:0] data_out;
  logic [3:0]  keep_out;
  logic        last_out;
  logic        ready_out = 1'b1;
  logic        err_short;

  axi_stream_extract_header #(.DATA_WD(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .valid_len(valid_len), .hdr_len(hdr_len), .ready_len(ready_len),
    .valid_in(valid_in), .data_in(data_in), .keep_in(keep_in), .last_in(last_in), .ready_in(ready_in),
    .valid_hdr(valid_hdr), .header_out(header_out), .keep_hdr(keep_hdr), .ready_hdr(ready_hdr),
    .valid_out(valid_out), .data_out(data_out), .keep_out(keep_out), .last_out(last_out), .ready_out(ready_out),
    .err_short(err_short)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [31:0] d; logic [3:0] k; logic l; } pay_t;
  typedef struct packed { logic [31:0] d; logic [3:0] k; } hdr_t;

  pay_t        exp_pay[$];
  hdr_t        exp_hdr[$];
  logic [31:0] pd[$];
  logic [3:0]  pk[$];
  int checks = 0, errors = 0, exp_err = 0, seen_err = 0, cyc = 0;
  bit mon_en = 1'b1, rnd_ready = 1'b0, in_fire = 1'b0, len_fire = 1'b0;
  bit held_out = 1'b0, held_h = 1'b0;
  pay_t held_pay;
  hdr_t held_hdr;
  int out_stall_at = -1, out_stall_n = 0, hdr_stall_at = -1, hdr_stall_n = 0;

  initial begin
    #500000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // One clock: sample and score at negedge, then drive after the next posedge.
  task automatic step();
    pay_t e;
    hdr_t h;
    @(negedge clk);
    in_fire  = valid_in && ready_in;
    len_fire = valid_len && ready_len;
    if (mon_en && rst_n) begin
      if (err_short === 1'b1) seen_err++;
      if (valid_out && ready_out) begin
        checks++;
        if (exp_pay.size() == 0) begin
          errors++;
          $display("FAIL payload_unexpected got %h/%b/%b", data_out, keep_out, last_out);
        end else begin
          e = exp_pay.pop_front();
          if ({data_out, keep_out, last_out} !== e) begin
            errors++;
            $display("FAIL payload got %h/%b/%b expected %h/%b/%b", data_out, keep_out, last_out, e.d, e.k, e.l);
          end
        end
      end
      if (valid_hdr && ready_hdr) begin
        checks++;
        if (exp_hdr.size() == 0) begin
          errors++;
          $display("FAIL header_unexpected got %h/%b", header_out, keep_hdr);
        end else begin
          h = exp_hdr.pop_front();
          if ({header_out, keep_hdr} !== h) begin
            errors++;
            $display("FAIL header got %h/%b expected %h/%b", header_out, keep_hdr, h.d, h.k);
          end
        end
      end
      if (valid_out && !ready_out) begin
        checks++;
        if (ready_in !== 1'b0) begin
          errors++;
          $display("FAIL ready_in_stall got %b expected 0", ready_in);
        end
        if (held_out) begin
          checks++;
          if ({data_out, keep_out, last_out} !== held_pay) begin
            errors++;
            $display("FAIL payload_hold got %h/%b/%b expected %h/%b/%b", data_out, keep_out, last_out,
                     held_pay.d, held_pay.k, held_pay.l);
          end
        end
        held_out = 1'b1;
        held_pay = {data_out, keep_out, last_out};
      end else held_out = 1'b0;
      if (valid_hdr && !ready_hdr) begin
        if (held_h) begin
          checks++;
          if ({header_out, keep_hdr} !== held_hdr) begin
            errors++;
            $display("FAIL header_hold got %h/%b expected %h/%b", header_out, keep_hdr, held_hdr.d, held_hdr.k);
          end
        end
        held_h   = 1'b1;
        held_hdr = {header_out, keep_hdr};
      end else held_h = 1'b0;
    end else begin
      held_out = 1'b0;
      held_h   = 1'b0;
    end
    @(posedge clk);
    #1;
    cyc++;
    ready_out = !(out_stall_at >= 0 && cyc >= out_stall_at && cyc < out_stall_at + out_stall_n)
                && (!rnd_ready || $urandom_range(0, 3) != 0);
    ready_hdr = !(hdr_stall_at >= 0 && cyc >= hdr_stall_at && cyc < hdr_stall_at + hdr_stall_n)
                && (!rnd_ready || $urandom_range(0, 3) != 0);
  endtask

  task automatic send_packet(input int L, input int nsend, output int max_wait);
    int t;
    max_wait  = 0;
    valid_len = 1'b1;
    hdr_len   = 3'(L);
    t = 0;
    do begin step(); t++; end while (!len_fire && t < 100);
    valid_len = 1'b0;
    if (!len_fire) begin
      checks++; errors++;
      $display("FAIL len_handshake got timeout expected ready_len");
      return;
    end
    for (int i = 0; i < nsend; i++) begin
      valid_in = 1'b1;
      data_in  = pd[i];
      keep_in  = pk[i];
      last_in  = (i == pd.size() - 1);
      t = 0;
      do begin step(); t++; end while (!in_fire && t < 100);
      if (!in_fire) begin
        checks++; errors++;
        $display("FAIL beat_handshake beat %0d got timeout expected ready_in", i);
        valid_in = 1'b0;
        return;
      end
      if (t > max_wait) max_wait = t;
    end
    valid_in = 1'b0;
    last_in  = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    step(); step();
    while ((exp_pay.size() != 0 || exp_hdr.size() != 0) && t < 200) begin step(); t++; end
    checks++;
    if (exp_pay.size() != 0 || exp_hdr.size() != 0) begin
      errors++;
      $display("FAIL drain got pending pay=%0d hdr=%0d expected 0", exp_pay.size(), exp_hdr.size());
      exp_pay.delete();
      exp_hdr.delete();
    end
    checks++;
    if (seen_err !== exp_err) begin
      errors++;
      $display("FAIL err_short_count got %0d expected %0d", seen_err, exp_err);
      seen_err = exp_err;
    end
  endtask

  // Reference: flatten the packet into bytes, then carve header and payload beats.
  task automatic model_push(input int L);
    logic [7:0]  bytes[$];
    logic [31:0] w;
    logic [3:0]  k;
    int leff, n0, np;
    hdr_t h;
    pay_t p;
    leff = (L == 0 || L > NB) ? NB : L;
    for (int i = 0; i < pd.size(); i++) begin
      w = pd[i];
      k = pk[i];
      for (int b = NB - 1; b >= 0; b--) if (k[b]) bytes.push_back(w[8*b +: 8]);
    end
    n0 = 0;
    k  = pk[0];
    for (int b = 0; b < NB; b++) if (k[b]) n0++;
    if (n0 < leff) begin
      leff = n0;
      exp_err++;
    end
    h = '0;
    for (int j = 0; j < leff; j++) begin
      h.d = {h.d[23:0], bytes[j]};
      h.k = {h.k[2:0], 1'b1};
    end
    exp_hdr.push_back(h);
    if (n0 >= ((L == 0 || L > NB) ? NB : L)) begin
      np = bytes.size() - leff;
      for (int s = 0; s < np; s += NB) begin
        p = '0;
        for (int j = 0; j < NB; j++) begin
          p.d = {p.d[23:0], (s + j < np) ? bytes[leff + s + j] : 8'h00};
          p.k = {p.k[2:0], (s + j < np)};
        end
        p.l = (s + NB >= np);
        exp_pay.push_back(p);
      end
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if ({ready_len, ready_in, valid_hdr, header_out, keep_hdr, valid_out, data_out, keep_out, last_out, err_short} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got len_rdy=%b in_rdy=%b vh=%b vo=%b err=%b expected all 0",
               ready_len, ready_in, valid_hdr, valid_out, err_short);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    step(); step();
    checks++;
    if (ready_len !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready_len got %b expected 1", ready_len);
    end
  endtask

  task automatic test_l3_two_beats();
    int w;
    pd = {32'hAABBCCDD, 32'h11223344};
    pk = {4'b1111, 4'b1111};
    exp_hdr.push_back({32'h00AABBCC, 4'b0111});
    exp_pay.push_back({32'hDD112233, 4'b1111, 1'b0});
    exp_pay.push_back({32'h44000000, 4'b1000, 1'b1});
    send_packet(3, 2, w);
    drain();
  endtask

  task automatic test_l4_passthrough();
    int w;
    pd = {32'h01020304, 32'h05060708, 32'h090A0B0C};
    pk = {4'b1111, 4'b1111, 4'b1100};
    exp_hdr.push_back({32'h01020304, 4'b1111});
    exp_pay.push_back({32'h05060708, 4'b1111, 1'b0});
    exp_pay.push_back({32'h090A0000, 4'b1100, 1'b1});
    send_packet(4, 3, w);
    checks++;
    if (w !== 1) begin
      errors++;
      $display("FAIL passthrough_bubble got max wait %0d expected 1", w);
    end
    drain();
  endtask

  task automatic test_l1_single();
    int w;
    pd = {32'hAABBCCDD};
    pk = {4'b1100};
    exp_hdr.push_back({32'h000000AA, 4'b0001});
    exp_pay.push_back({32'hBB000000, 4'b1000, 1'b1});
    send_packet(1, 1, w);
    drain();
  endtask

  task automatic test_short();
    int w;
    pd = {32'hAABBCCDD};
    pk = {4'b1000};
    exp_hdr.push_back({32'h000000AA, 4'b0001});
    exp_err++;
    send_packet(2, 1, w);
    drain();
  endtask

  task automatic test_stall();
    int w;
    pd = {32'h10111213, 32'h20212223, 32'h30313233, 32'h40414243, 32'h505152FF};
    pk = {4'b1111, 4'b1111, 4'b1111, 4'b1111, 4'b1110};
    model_push(3);
    hdr_stall_at = cyc + 1; hdr_stall_n = 5;
    out_stall_at = cyc + 4; out_stall_n = 3;
    send_packet(3, 5, w);
    drain();
    hdr_stall_at = -1; out_stall_at = -1;
  endtask

  task automatic test_back_to_back();
    int w;
    pd = {32'hC0C1C2C3, 32'hD0D1D2D3, 32'hE0E1E2E3};
    pk = {4'b1111, 4'b1111, 4'b1110};
    model_push(2);
    send_packet(2, 3, w);
    pd = {32'hF0F1F2F3};
    pk = {4'b1111};
    model_push(0);
    send_packet(0, 1, w);
    drain();
  endtask

  task automatic test_reset_mid_body();
    int w;
    pd = {32'h01010101, 32'h02020202, 32'h03030303, 32'h04040404};
    pk = {4'b1111, 4'b1111, 4'b1111, 4'b1111};
    mon_en = 1'b0;
    send_packet(2, 2, w);
    rst_n    = 1'b0;
    valid_in = 1'b0;
    @(negedge clk);
    checks++;
    if ({valid_hdr, header_out, keep_hdr, valid_out, data_out, keep_out, last_out, err_short, ready_in, ready_len} !== '0) begin
      errors++;
      $display("FAIL midreset_outputs got vh=%b hdr=%h vo=%b do=%h err=%b expected all 0",
               valid_hdr, header_out, valid_out, data_out, err_short);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    step(); step();
    checks++;
    if (ready_len !== 1'b1) begin
      errors++;
      $display("FAIL midreset_ready_len got %b expected 1", ready_len);
    end
    mon_en = 1'b1;
    pd = {32'h99887766, 32'h55443322};
    pk = {4'b1111, 4'b1000};
    exp_hdr.push_back({32'h00998877, 4'b0111});
    exp_pay.push_back({32'h66550000, 4'b1100, 1'b1});
    send_packet(3, 2, w);
    drain();
  endtask

  task automatic test_random();
    int w, nb, L;
    logic [3:0] k;
    rnd_ready = 1'b1;
    for (int p = 0; p < 12; p++) begin
      pd.delete();
      pk.delete();
      nb = $urandom_range(1, 4);
      L  = $urandom_range(0, 7);
      for (int i = 0; i < nb; i++) begin
        pd.push_back($urandom);
        k = 4'hF;
        if (i == nb - 1) k = k << (NB - $urandom_range(1, 4));
        pk.push_back(k);
      end
      model_push(L);
      send_packet(L, nb, w);
      drain();
    end
    rnd_ready = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_l3_two_beats();
    test_l4_passthrough();
    test_l1_single();
    test_short();
    test_stall();
    test_back_to_back();
    test_reset_mid_body();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
